// File: rtl/match_datapath.sv
// Pattern-match datapath: pattern/sequence memories, pc/wc/lc counters and the
// per-read classification of the current pattern word against the current letter.
module match_datapath #(
    parameter int unsigned PAW = 4,
    parameter int unsigned SAW = 6
) (
    input  logic           clock,
    input  logic           reset_N,
    input  logic           p_we,
    input  logic [PAW-1:0] p_waddr,
    input  logic [7:0]     p_wdata,
    input  logic           s_we,
    input  logic [SAW-1:0] s_waddr,
    input  logic [4:0]     s_wdata,
    input  logic [PAW-1:0] pc_base,
    input  logic [SAW-1:0] wc_base,
    input  logic [SAW:0]   seq_len,
    input  logic           en_pc,
    input  logic           cl_pc,
    input  logic           ld_pc,
    input  logic           en_wc,
    input  logic           cl_wc,
    input  logic           ld_wc,
    input  logic           en_lc,
    input  logic           cl_lc,
    input  logic           re_p,
    input  logic           re_s,
    output logic [2:0]     fsm_notif,
    output logic           end_seq,
    output logic           len_reached,
    output logic [PAW-1:0] pc,
    output logic [SAW-1:0] wc
);

    logic [7:0] pmem [2**PAW];
    logic [4:0] smem [2**SAW];

    logic [4:0] lc;
    logic [7:0] pat_q;
    logic [4:0] let_q;
    logic [4:0] rep_len;
    logic       rep_valid;
    logic       seq_valid;
    logic       pat_valid;
    logic       end_q;
    logic [7:0] rd_word;

    // Memories carry no reset so host-loaded contents survive a controller reset.
    always_ff @(posedge clock) begin
        if (p_we) pmem[p_waddr] <= p_wdata;
        if (s_we) smem[s_waddr] <= s_wdata;
    end

    assign rd_word = pmem[pc];

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            pc <= '0;
            wc <= '0;
            lc <= '0;
        end else begin
            if (en_pc) begin
                if (cl_pc)      pc <= '0;
                else if (ld_pc) pc <= pc_base;
                else            pc <= pc + PAW'(1);
            end
            if (en_wc) begin
                if (cl_wc)      wc <= '0;
                else if (ld_wc) wc <= wc_base;
                else            wc <= wc + SAW'(1);
            end
            if (en_lc) begin
                if (cl_lc) lc <= '0;
                else       lc <= lc + 5'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            pat_q     <= '0;
            let_q     <= '0;
            rep_len   <= '0;
            rep_valid <= 1'b0;
            seq_valid <= 1'b0;
            pat_valid <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            if (re_p) begin
                pat_q     <= rd_word;
                pat_valid <= 1'b1;
                if (rd_word[7:5] == 3'd5 || rd_word[7:5] == 3'd6) begin
                    rep_len   <= rd_word[4:0];
                    rep_valid <= 1'b1;
                end
            end
            if (re_s) begin
                let_q     <= smem[wc];
                seq_valid <= 1'b1;
                end_q     <= ({1'b0, wc} >= seq_len);
            end
        end
    end

    assign end_seq     = seq_valid && end_q;
    assign len_reached = rep_valid && (lc == rep_len);

    always_comb begin
        fsm_notif = 3'd0;
        if (pat_valid) begin
            unique case (pat_q[7:5])
                3'd0:    fsm_notif = (let_q == pat_q[4:0]) ? 3'd0 : 3'd1;
                3'd1:    fsm_notif = 3'd1;
                3'd2:    fsm_notif = 3'd2;
                default: fsm_notif = pat_q[7:5];
            endcase
        end
    end

endmodule

// File: tb/tb_match_datapath.sv
// Self-checking bench for match_datapath: expected read results are queued when a
// read strobe is driven and popped once the DUT output for that read is valid.
module tb_match_datapath;

    localparam int unsigned PAW = 4;
    localparam int unsigned SAW = 6;

    logic           clock = 1'b0;
    logic           reset_N;
    logic           p_we, s_we;
    logic [PAW-1:0] p_waddr, pc_base;
    logic [7:0]     p_wdata;
    logic [SAW-1:0] s_waddr, wc_base;
    logic [4:0]     s_wdata;
    logic [SAW:0]   seq_len;
    logic           en_pc, cl_pc, ld_pc, en_wc, cl_wc, ld_wc, en_lc, cl_lc, re_p, re_s;
    logic [2:0]     fsm_notif;
    logic           end_seq, len_reached;
    logic [PAW-1:0] pc;
    logic [SAW-1:0] wc;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_notif [$];
    logic       exp_end [$];

    match_datapath #(.PAW(PAW), .SAW(SAW)) dut (
        .clock(clock), .reset_N(reset_N),
        .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
        .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata),
        .pc_base(pc_base), .wc_base(wc_base), .seq_len(seq_len),
        .en_pc(en_pc), .cl_pc(cl_pc), .ld_pc(ld_pc),
        .en_wc(en_wc), .cl_wc(cl_wc), .ld_wc(ld_wc),
        .en_lc(en_lc), .cl_lc(cl_lc), .re_p(re_p), .re_s(re_s),
        .fsm_notif(fsm_notif), .end_seq(end_seq), .len_reached(len_reached),
        .pc(pc), .wc(wc)
    );

    always #5 clock = ~clock;

    task automatic idle();
        p_we = 0; s_we = 0; en_pc = 0; cl_pc = 0; ld_pc = 0;
        en_wc = 0; cl_wc = 0; ld_wc = 0; en_lc = 0; cl_lc = 0; re_p = 0; re_s = 0;
    endtask

    // One edge, then settle away from it before sampling.
    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic wr_p(input logic [PAW-1:0] a, input logic [7:0] d);
        p_we = 1; p_waddr = a; p_wdata = d;
        step();
    endtask

    task automatic wr_s(input logic [SAW-1:0] a, input logic [4:0] d);
        s_we = 1; s_waddr = a; s_wdata = d;
        step();
    endtask

    task automatic load_pc(input logic [PAW-1:0] v);
        en_pc = 1; ld_pc = 1; pc_base = v;
        step();
    endtask

    task automatic pop_notif(input string name);
        logic [2:0] e;
        checks++;
        if (exp_notif.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got fsm_notif=%0d", name, fsm_notif);
        end else begin
            e = exp_notif.pop_front();
            if (fsm_notif !== e) begin
                errors++;
                $display("FAIL %s: fsm_notif got %0d expected %0d", name, fsm_notif, e);
            end
        end
    endtask

    task automatic pop_end(input string name);
        logic e;
        checks++;
        if (exp_end.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got end_seq=%0b", name, end_seq);
        end else begin
            e = exp_end.pop_front();
            if (end_seq !== e) begin
                errors++;
                $display("FAIL %s: end_seq got %0b expected %0b", name, end_seq, e);
            end
        end
    endtask

    task automatic test_reset();
        reset_N = 0;
        step();
        step();
        reset_N = 1;
        step();
        checks++;
        if ({pc, wc, fsm_notif, end_seq, len_reached} !== '0) begin
            errors++;
            $display("FAIL reset: pc=%0d wc=%0d notif=%0d end=%0b len=%0b expected all 0",
                     pc, wc, fsm_notif, end_seq, len_reached);
        end
    endtask

    task automatic test_literal();
        wr_p(0, 8'h03);
        wr_s(0, 5'h03);
        seq_len = 7'd4;
        re_p = 1; re_s = 1;
        exp_notif.push_back(3'd0); exp_end.push_back(1'b0);
        step();
        pop_notif("literal_match");
        pop_end("literal_end");
        wr_s(0, 5'h04);
        re_p = 1; re_s = 1;
        exp_notif.push_back(3'd1);
        step();
        pop_notif("literal_mismatch");
    endtask

    task automatic test_repeat();
        wr_p(2, 8'hA3);
        load_pc(2);
        checks++;
        if (pc !== 4'd2) begin errors++; $display("FAIL ld_pc: pc got %0d expected 2", pc); end
        re_p = 1;
        exp_notif.push_back(3'd5);
        step();
        pop_notif("repeat_exact");
        checks++;
        if (len_reached !== 1'b0) begin
            errors++; $display("FAIL len_lc0: len_reached got %0b expected 0", len_reached);
        end
        for (int i = 0; i < 3; i++) begin
            en_lc = 1;
            step();
        end
        checks++;
        if (len_reached !== 1'b1) begin
            errors++; $display("FAIL len_lc3: len_reached got %0b expected 1", len_reached);
        end
        en_lc = 1; cl_lc = 1;
        step();
        checks++;
        if (len_reached !== 1'b0) begin
            errors++; $display("FAIL len_clear: len_reached got %0b expected 0", len_reached);
        end
        // Zero-length repeat must report reached as soon as it is read.
        wr_p(3, 8'hC0);
        load_pc(3);
        re_p = 1;
        exp_notif.push_back(3'd6);
        step();
        pop_notif("repeat_upto");
        checks++;
        if (len_reached !== 1'b1) begin
            errors++; $display("FAIL len_zero: len_reached got %0b expected 1", len_reached);
        end
    endtask

    task automatic test_end_seq();
        seq_len = 7'd2;
        en_wc = 1; step();
        en_wc = 1; step();
        checks++;
        if (wc !== 6'd2) begin errors++; $display("FAIL wc_inc: wc got %0d expected 2", wc); end
        re_s = 1; exp_end.push_back(1'b1);
        step();
        pop_end("end_at_len");
        en_wc = 1; ld_wc = 1; wc_base = 0;
        step();
        re_s = 1; exp_end.push_back(1'b0);
        step();
        pop_end("end_below_len");
        seq_len = 7'd0;
        re_s = 1; exp_end.push_back(1'b1);
        step();
        pop_end("end_len_zero");
        en_wc = 1; ld_wc = 1; wc_base = 6'd63;
        step();
        en_wc = 1;
        step();
        checks++;
        if (wc !== 6'd0) begin errors++; $display("FAIL wc_wrap: wc got %0d expected 0", wc); end
    endtask

    task automatic test_priority();
        load_pc(5);
        en_pc = 1; cl_pc = 1; ld_pc = 1; pc_base = 5;
        step();
        checks++;
        if (pc !== 4'd0) begin errors++; $display("FAIL clr_prio: pc got %0d expected 0", pc); end
        en_pc = 1; ld_pc = 1; pc_base = 9;
        step();
        checks++;
        if (pc !== 4'd9) begin errors++; $display("FAIL ld_prio: pc got %0d expected 9", pc); end
        cl_pc = 1; ld_pc = 1; pc_base = 3;
        step();
        checks++;
        if (pc !== 4'd9) begin errors++; $display("FAIL pc_hold: pc got %0d expected 9", pc); end
        load_pc(15);
        en_pc = 1;
        step();
        checks++;
        if (pc !== 4'd0) begin errors++; $display("FAIL pc_wrap: pc got %0d expected 0", pc); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        for (int op = 1; op < 8; op++) wr_p(PAW'(8 + op), {3'(op), 5'h1f});
        load_pc(9);
        // Each read uses pc before its same-cycle increment.
        for (int op = 1; op < 8; op++) begin
            e = (op == 1) ? 3'd1 : (op == 2) ? 3'd2 : 3'(op);
            re_p = 1; en_pc = 1;
            exp_notif.push_back(e);
            step();
            pop_notif($sformatf("b2b_op%0d", op));
        end
        // pc has wrapped to 0: pmem[0] = 8'h03, let_q = 5'h04. Overwrite during read.
        re_p = 1; p_we = 1; p_waddr = 0; p_wdata = 8'h40;
        exp_notif.push_back(3'd1);
        step();
        pop_notif("rd_old_data");
        re_p = 1;
        exp_notif.push_back(3'd2);
        step();
        pop_notif("rd_new_data");
    endtask

    task automatic test_midrun_reset();
        wr_p(1, 8'h40);
        load_pc(1);
        re_p = 1; re_s = 1; seq_len = 7'd0;
        exp_notif.push_back(3'd2); exp_end.push_back(1'b1);
        step();
        pop_notif("illegal");
        pop_end("pre_reset_end");
        reset_N = 0;
        step();
        reset_N = 1;
        checks++;
        if ({pc, wc, fsm_notif, end_seq, len_reached} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: pc=%0d wc=%0d notif=%0d end=%0b len=%0b expected all 0",
                     pc, wc, fsm_notif, end_seq, len_reached);
        end
        load_pc(1);
        re_p = 1;
        exp_notif.push_back(3'd2);
        step();
        pop_notif("mem_kept");
    endtask

    initial begin
        idle();
        reset_N = 0; p_waddr = 0; p_wdata = 0; s_waddr = 0; s_wdata = 0;
        pc_base = 0; wc_base = 0; seq_len = 0;
        #1;
        test_reset();
        test_literal();
        test_repeat();
        test_end_seq();
        test_priority();
        test_back_to_back();
        test_midrun_reset();
        checks++;
        if (exp_notif.size() != 0 || exp_end.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d left, expected 0",
                     exp_notif.size(), exp_end.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_datapath.md
Name: match_datapath

Overview:
- Datapath paired with the pattern-match controller FSM. Holds the pattern memory and the sequence memory, plus the pattern, word and length counters.
- Executes the controller's enable, clear, load and read strobes.
- Each read cycle classifies the current pattern word against the current sequence letter and returns a 3-bit notification code, an end-of-sequence flag and a length-reached flag.
- A host loads both memories before asserting ready to the controller.

Parameters:
PAW, 4, pattern address width (pattern memory depth 2**PAW)
SAW, 6, sequence address width (sequence memory depth 2**SAW)

Ports:
clock  input  1  clock
reset_N  input  1  synchronous active-low reset
p_we  input  1  host pattern-memory write enable
p_waddr  input  PAW  host pattern write address
p_wdata  input  8  pattern word: [7:5] opcode, [4:0] operand
s_we  input  1  host sequence-memory write enable
s_waddr  input  SAW  host sequence write address
s_wdata  input  5  sequence letter
pc_base  input  PAW  pattern counter load value
wc_base  input  SAW  word counter load value
seq_len  input  SAW+1  number of valid letters starting at address 0
en_pc, cl_pc, ld_pc  input  1  pattern counter controls
en_wc, cl_wc, ld_wc  input  1  word counter controls
en_lc, cl_lc  input  1  length counter controls
re_p, re_s  input  1  pattern / sequence read strobes
fsm_notif  output  3  classification code
end_seq  output  1  word counter at or past seq_len on last sequence read
len_reached  output  1  repeat length satisfied
pc, wc  output  PAW, SAW  current counter values (debug)

Behaviour:
- Clock and reset: all state updates on posedge clock. Reset is synchronous, active-low, on reset_N.
- Reset values:
  - pc = 0, wc = 0, lc = 0.
  - Read registers pat_q = 0, let_q = 0.
  - rep_len = 0, rep_valid = 0, seq_valid = 0.
  - Outputs fsm_notif = 0, end_seq = 0, len_reached = 0.
  - Memory contents are not reset.
- Reset mid-operation: memory contents preserved; all registers return to reset values.
- Counters (pc, wc and lc identical):
  - Hold when en = 0.
  - When en = 1, priority is clear (to 0), then load (pc_base / wc_base), then increment.
  - Increment wraps modulo 2**width.
  - lc is 5 bits and has no load.
- Memories:
  - Synchronous write on p_we / s_we.
  - Registered read: when re_p = 1, pat_q <= pmem[pc] at the edge; when re_s = 1, let_q <= smem[wc]. Registers hold otherwise.
  - Read uses the counter value before any same-cycle counter update.
  - Read and write to the same address in one cycle: the read returns the old data.
- Sequence flags on each re_s edge:
  - seq_valid <= 1.
  - end_seq <= (wc >= seq_len), zero-extended compare.
  - seq_len = 0 means the first read flags end_seq.
- Repeat length: on a re_p edge whose read word has opcode 5 or 6, rep_len <= operand and rep_valid <= 1.
- len_reached = rep_valid && (lc == rep_len).
  - rep_len = 0 gives len_reached immediately after the repeat word is read.
- fsm_notif is combinational from pat_q / let_q. Opcode op = pat_q[7:5].
  - op 0 (literal): 0 if let_q == pat_q[4:0], else 1.
  - op 1: 1 (unconditional mismatch).
  - op 2: 2 (illegal/error).
  - op 3..7: fsm_notif = op. Meanings: 3 = two-alternative, 4 = three-alternative, 5 = repeat-exactly, 6 = repeat-up-to, 7 = pattern complete.
  - Before the first re_p after reset: 0.
- Latency: strobes and counter controls take effect at the next edge. fsm_notif, end_seq and len_reached are valid in the cycle after the read strobe.
- Simultaneous host write and controller read are permitted; no stall or handshake.

Test Plan:
1. Reset then no strobes -> pc = wc = lc = 0, fsm_notif = 0, end_seq = 0, len_reached = 0.
2. pmem[0] = 8'h03 (literal 'd'), smem[0] = 5'h03, seq_len = 4; pulse re_p, re_s -> next cycle fsm_notif = 0. Set smem[0] = 5'h04 and repeat -> fsm_notif = 1.
3. pmem[2] = 8'hA3 (op 5, len 3); ld_pc with pc_base = 2, then re_p -> fsm_notif = 5, len_reached = 0.
   - Pulse en_lc 3 times -> len_reached = 1.
   - en_lc + cl_lc -> lc = 0, len_reached = 0.
4. seq_len = 2: en_wc increments to wc = 2, then re_s -> end_seq = 1. ld_wc with wc_base = 0, then re_s -> end_seq = 0.
5. Priority: en_pc = cl_pc = ld_pc = 1 with pc = 5 -> pc = 0. en_pc = ld_pc = 1, pc_base = 9 -> pc = 9. pc = 15, en_pc -> pc = 0.
6. pmem[1] = 8'h40 (op 2), read -> fsm_notif = 2. Assert reset_N = 0 mid-run -> all outputs 0 next edge; pmem[1] still reads 8'h40 afterwards.
